// File: rtl/dram_apb_csr.sv
// APB completer holding the DRAM controller's timing/control registers and
// launching one-shot commands to the controller core over valid/ready.
module dram_apb_csr #(
  parameter int unsigned NUM_WAIT  = 1,
  parameter logic [15:0] TREFI_RST = 16'd780
) (
  input  logic        pclk,
  input  logic        preset,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [15:0] paddr,
  input  logic [15:0] pwdata,
  output logic [15:0] prdata,
  output logic        pready,
  output logic        pslverr,
  output logic        cfg_enable,
  output logic        cfg_refresh_en,
  output logic [15:0] cfg_trefi,
  output logic [3:0]  cfg_trcd,
  output logic [3:0]  cfg_trp,
  output logic [3:0]  cfg_tcas,
  output logic        cmd_valid,
  output logic [1:0]  cmd_op,
  output logic [15:0] cmd_addr,
  input  logic        cmd_ready,
  input  logic        core_busy,
  input  logic        init_done
);

  localparam logic [15:0] ADDR_CTRL     = 16'h0000;
  localparam logic [15:0] ADDR_TREFI    = 16'h0002;
  localparam logic [15:0] ADDR_TIMING   = 16'h0004;
  localparam logic [15:0] ADDR_CMD_ADDR = 16'h0006;
  localparam logic [15:0] ADDR_CMD      = 16'h0008;
  localparam logic [15:0] ADDR_STATUS   = 16'h000A;

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t      state, state_next;
  logic [3:0]  cnt, cnt_next;
  logic [1:0]  ctrl;
  logic [15:0] trefi;
  logic [11:0] timing;
  logic [15:0] cmd_addr_q;
  logic [15:0] rd_mux;
  logic        err;
  logic        commit;

  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Dropping psel during ACCESS abandons the transfer without a response.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (psel && !penable) begin
          state_next = ACCESS;
          cnt_next   = 4'(NUM_WAIT);
        end
      end
      ACCESS: begin
        if (!psel) begin
          state_next = IDLE;
        end else if (penable) begin
          if (cnt == 4'd0) state_next = IDLE;
          else             cnt_next   = cnt - 4'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign pready = (state == ACCESS) && (cnt == 4'd0) && psel && penable;

  // Pending command locks both CMD and CMD_ADDR against writes.
  always_comb begin
    rd_mux = 16'h0000;
    err    = 1'b0;
    case (paddr)
      ADDR_CTRL:     rd_mux = {14'b0, ctrl};
      ADDR_TREFI:    rd_mux = trefi;
      ADDR_TIMING:   rd_mux = {4'b0, timing};
      ADDR_CMD_ADDR: begin
        rd_mux = cmd_addr_q;
        err    = pwrite && cmd_valid;
      end
      ADDR_CMD:      err = !pwrite || cmd_valid;
      ADDR_STATUS:   begin
        rd_mux = {13'b0, init_done, core_busy, cmd_valid};
        err    = pwrite;
      end
      default:       err = 1'b1;
    endcase
  end

  assign prdata  = (pready && !err) ? rd_mux : 16'h0000;
  assign pslverr = pready && err;
  assign commit  = pready && pwrite && !err;

  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      ctrl       <= 2'b00;
      trefi      <= TREFI_RST;
      timing     <= 12'h333;
      cmd_addr_q <= 16'h0000;
      cmd_valid  <= 1'b0;
      cmd_op     <= 2'b00;
    end else begin
      if (commit) begin
        case (paddr)
          ADDR_CTRL:     ctrl       <= pwdata[1:0];
          ADDR_TREFI:    trefi      <= pwdata;
          ADDR_TIMING:   timing     <= pwdata[11:0];
          ADDR_CMD_ADDR: cmd_addr_q <= pwdata;
          default: ;
        endcase
      end
      if (commit && paddr == ADDR_CMD) begin
        cmd_valid <= 1'b1;
        cmd_op    <= pwdata[1:0];
      end else if (cmd_valid && cmd_ready) begin
        cmd_valid <= 1'b0;
      end
    end
  end

  assign cfg_enable     = ctrl[0];
  assign cfg_refresh_en = ctrl[1];
  assign cfg_trefi      = trefi;
  assign cfg_trcd       = timing[3:0];
  assign cfg_trp        = timing[7:4];
  assign cfg_tcas       = timing[11:8];
  assign cmd_addr       = cmd_addr_q;

endmodule

// File: tb/tb_dram_apb_csr.sv
// Self-checking bench for dram_apb_csr: directed and random APB traffic
// compared against a register-level reference model.
module tb_dram_apb_csr;

  logic        pclk = 1'b0;
  logic        preset = 1'b0;
  logic        psel_a = 1'b0;
  logic        use3 = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [15:0] paddr = 16'h0;
  logic [15:0] pwdata = 16'h0;
  logic        cmd_ready = 1'b0;
  logic        core_busy = 1'b0;
  logic        init_done = 1'b0;

  logic [15:0] prdata1, prdata3, cfg_trefi1, cfg_trefi3, cmd_addr1, cmd_addr3;
  logic        pready1, pready3, pslverr1, pslverr3;
  logic        en1, en3, ref1, ref3, cv1, cv3;
  logic [3:0]  trcd1, trcd3, trp1, trp3, tcas1, tcas3;
  logic [1:0]  op1, op3;

  int errors = 0;
  int checks = 0;

  always #5 pclk = ~pclk;

  dram_apb_csr #(.NUM_WAIT(1), .TREFI_RST(16'd780)) dut (
    .pclk(pclk), .preset(preset), .psel(psel_a && !use3), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata1),
    .pready(pready1), .pslverr(pslverr1), .cfg_enable(en1), .cfg_refresh_en(ref1),
    .cfg_trefi(cfg_trefi1), .cfg_trcd(trcd1), .cfg_trp(trp1), .cfg_tcas(tcas1),
    .cmd_valid(cv1), .cmd_op(op1), .cmd_addr(cmd_addr1), .cmd_ready(cmd_ready),
    .core_busy(core_busy), .init_done(init_done)
  );

  dram_apb_csr #(.NUM_WAIT(3), .TREFI_RST(16'd780)) dut3 (
    .pclk(pclk), .preset(preset), .psel(psel_a && use3), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata3),
    .pready(pready3), .pslverr(pslverr3), .cfg_enable(en3), .cfg_refresh_en(ref3),
    .cfg_trefi(cfg_trefi3), .cfg_trcd(trcd3), .cfg_trp(trp3), .cfg_tcas(tcas3),
    .cmd_valid(cv3), .cmd_op(op3), .cmd_addr(cmd_addr3), .cmd_ready(1'b0),
    .core_busy(core_busy), .init_done(init_done)
  );

  wire        cur_pready  = use3 ? pready3 : pready1;
  wire [15:0] cur_prdata  = use3 ? prdata3 : prdata1;
  wire        cur_pslverr = use3 ? pslverr3 : pslverr1;

  // Reference model of the NUM_WAIT=1 instance's architectural registers.
  logic [1:0]  m_ctrl;
  logic [15:0] m_trefi;
  logic [11:0] m_timing;
  logic [15:0] m_cmd_addr;
  logic        m_cmd_valid;
  logic [1:0]  m_cmd_op;

  function automatic void model_reset();
    m_ctrl = 2'b0; m_trefi = 16'd780; m_timing = 12'h333;
    m_cmd_addr = 16'h0; m_cmd_valid = 1'b0; m_cmd_op = 2'b0;
  endfunction

  function automatic bit model_err(input bit wr, input logic [15:0] a);
    if (a[0] || a > 16'h000A) return 1'b1;
    if (wr && a == 16'h000A) return 1'b1;
    if (!wr && a == 16'h0008) return 1'b1;
    if (wr && (a == 16'h0008 || a == 16'h0006) && m_cmd_valid) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [15:0] model_read(input logic [15:0] a);
    case (a)
      16'h0000: return {14'b0, m_ctrl};
      16'h0002: return m_trefi;
      16'h0004: return {4'b0, m_timing};
      16'h0006: return m_cmd_addr;
      16'h000A: return {13'b0, init_done, core_busy, m_cmd_valid};
      default:  return 16'h0;
    endcase
  endfunction

  function automatic void model_write(input logic [15:0] a, input logic [15:0] d);
    case (a)
      16'h0000: m_ctrl = d[1:0];
      16'h0002: m_trefi = d;
      16'h0004: m_timing = d[11:0];
      16'h0006: m_cmd_addr = d;
      16'h0008: begin m_cmd_valid = 1'b1; m_cmd_op = d[1:0]; end
      default: ;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One APB transfer; waits is the number of ACCESS cycles seen before pready.
  task automatic applyStimulus(input bit sel3, input bit wr, input logic [15:0] a,
                               input logic [15:0] d, output logic [15:0] rd,
                               output logic err, output int waits);
    @(negedge pclk);
    use3 = sel3; psel_a = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
    @(negedge pclk);
    penable = 1'b1;
    waits = 0;
    #1;
    while (!cur_pready && waits < 20) begin
      @(negedge pclk); #1;
      waits++;
    end
    if (waits >= 20) checkOutput("pready_timeout", 32'(waits), 32'(sel3 ? 3 : 1));
    rd = cur_prdata;
    err = cur_pslverr;
    @(posedge pclk); #1;
    psel_a = 1'b0; penable = 1'b0;
  endtask

  task automatic modelXfer(input string tag, input bit wr, input logic [15:0] a, input logic [15:0] d);
    logic [15:0] rd;
    logic        err;
    int          waits;
    bit          exp_err;
    logic [15:0] exp_rd;
    exp_err = model_err(wr, a);
    exp_rd  = (wr || exp_err) ? 16'h0 : model_read(a);
    applyStimulus(1'b0, wr, a, d, rd, err, waits);
    if (!wr) checkOutput({tag, "_prdata"}, 32'(rd), 32'(exp_rd));
    checkOutput({tag, "_pslverr"}, 32'(err), 32'(exp_err));
    checkOutput({tag, "_waits"}, 32'(waits), 32'd1);
    if (wr && !exp_err) model_write(a, d);
  endtask

  task automatic checkState(input string tag);
    checkOutput({tag, "_cfg"}, {en1, ref1, trcd1, trp1, tcas1, cfg_trefi1},
                {m_ctrl[0], m_ctrl[1], m_timing[3:0], m_timing[7:4], m_timing[11:8], m_trefi});
    checkOutput({tag, "_cmd"}, {13'b0, cv1, op1, cmd_addr1}, {13'b0, m_cmd_valid, m_cmd_op, m_cmd_addr});
  endtask

  task automatic pulseReady();
    @(negedge pclk); cmd_ready = 1'b1;
    @(negedge pclk); cmd_ready = 1'b0;
    m_cmd_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [15:0] rd;
    logic        err;
    int          waits;
    logic [15:0] addr_list [9];
    addr_list = '{16'h0000, 16'h0002, 16'h0004, 16'h0006, 16'h0008, 16'h000A,
                  16'h0003, 16'h0020, 16'h000C};

    model_reset();
    repeat (3) @(negedge pclk);
    #1;
    checkOutput("reset_pready", 32'(pready1), 32'd0);
    checkOutput("reset_prdata", 32'(prdata1), 32'd0);
    checkOutput("reset_pslverr", 32'(pslverr1), 32'd0);
    checkState("reset");
    preset = 1'b1;

    // Reset values through the bus; a read also checks prdata stays 0 before pready.
    @(negedge pclk);
    psel_a = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 16'h0002;
    @(negedge pclk); penable = 1'b1; #1;
    checkOutput("wait_pready_low", 32'(pready1), 32'd0);
    checkOutput("wait_prdata_zero", 32'(prdata1), 32'd0);
    @(negedge pclk); #1;
    checkOutput("trefi_pready", 32'(pready1), 32'd1);
    checkOutput("trefi_read", 32'(prdata1), 32'd780);
    @(posedge pclk); #1; psel_a = 1'b0; penable = 1'b0;
    modelXfer("timing_rst", 1'b0, 16'h0004, 16'h0);
    modelXfer("ctrl_rst", 1'b0, 16'h0000, 16'h0);

    // TIMING write drops the upper nibble; fields drive the cfg outputs.
    modelXfer("timing_wr", 1'b1, 16'h0004, 16'hF5A7);
    checkOutput("tcas_trp_trcd", {20'b0, tcas1, trp1, trcd1}, 32'h5A7);
    modelXfer("timing_rd", 1'b0, 16'h0004, 16'h0);
    modelXfer("ctrl_wr", 1'b1, 16'h0000, 16'hFFFF);
    modelXfer("ctrl_rd", 1'b0, 16'h0000, 16'h0);
    checkState("after_ctrl");

    // Command launch and its lock-out while pending.
    modelXfer("cmdaddr_wr", 1'b1, 16'h0006, 16'h1234);
    modelXfer("cmd_wr", 1'b1, 16'h0008, 16'h0002);
    checkOutput("cmd_fields", {13'b0, cv1, op1, cmd_addr1}, {13'b0, 1'b1, 2'd2, 16'h1234});
    modelXfer("cmd_busy", 1'b1, 16'h0008, 16'h0001);
    modelXfer("cmdaddr_busy", 1'b1, 16'h0006, 16'hBEEF);
    checkState("pending");
    pulseReady();
    #1;
    checkOutput("cmd_cleared", 32'(cv1), 32'd0);
    modelXfer("status_rd", 1'b0, 16'h000A, 16'h0);

    // Bad accesses.
    modelXfer("odd_rd", 1'b0, 16'h0003, 16'h0);
    modelXfer("odd_wr", 1'b1, 16'h0003, 16'hFFFF);
    modelXfer("unmap_rd", 1'b0, 16'h0020, 16'h0);
    modelXfer("unmap_wr", 1'b1, 16'h0020, 16'hFFFF);
    modelXfer("status_wr", 1'b1, 16'h000A, 16'hFFFF);
    modelXfer("cmd_rd", 1'b0, 16'h0008, 16'h0);
    checkState("after_errors");

    // Random traffic against the model.
    for (int i = 0; i < 60; i++) begin
      logic [15:0] a;
      a = addr_list[$urandom_range(8, 0)];
      core_busy = 1'($urandom);
      init_done = 1'($urandom);
      modelXfer("rand", 1'($urandom), a, 16'($urandom));
      if ($urandom_range(3, 0) == 0) pulseReady();
      #1;
      checkState("rand_state");
    end

    // Aborted write on the NUM_WAIT=3 instance.
    @(negedge pclk);
    use3 = 1'b1; psel_a = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 16'h0000; pwdata = 16'h0003;
    @(negedge pclk); penable = 1'b1; #1;
    checkOutput("abort_wait1", 32'(pready3), 32'd0);
    @(negedge pclk); #1;
    checkOutput("abort_wait2", 32'(pready3), 32'd0);
    psel_a = 1'b0; penable = 1'b0;
    repeat (3) @(negedge pclk);
    #1;
    checkOutput("abort_noresp", 32'(pready3), 32'd0);
    checkOutput("abort_nowrite", {30'b0, ref3, en3}, 32'd0);
    applyStimulus(1'b1, 1'b1, 16'h0000, 16'h0003, rd, err, waits);
    checkOutput("w3_waits", 32'(waits), 32'd3);
    checkOutput("w3_err", 32'(err), 32'd0);
    applyStimulus(1'b1, 1'b0, 16'h0000, 16'h0, rd, err, waits);
    checkOutput("w3_read", 32'(rd), 32'd3);
    use3 = 1'b0;

    // Asynchronous reset in the middle of an ACCESS with a pending command.
    if (m_cmd_valid) pulseReady();
    modelXfer("pre_rst_cmd", 1'b1, 16'h0008, 16'h0003);
    modelXfer("pre_rst_trefi", 1'b1, 16'h0002, 16'h1111);
    @(negedge pclk);
    psel_a = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 16'h0002;
    @(negedge pclk); penable = 1'b1;
    @(negedge pclk); #2;
    preset = 1'b0;
    #1;
    model_reset();
    checkOutput("rst_pready", 32'(pready1), 32'd0);
    checkOutput("rst_prdata", 32'(prdata1), 32'd0);
    checkState("rst_mid");
    @(negedge pclk);
    psel_a = 1'b0; penable = 1'b0;
    @(negedge pclk);
    preset = 1'b1;
    modelXfer("post_rst_trefi", 1'b0, 16'h0002, 16'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dram_apb_csr.md
Name: dram_apb_csr

Overview:
- APB completer (slave) that terminates the DRAM controller's configuration bus.
- Holds the controller's timing and control registers, exposes core status, and launches one-shot DRAM commands to the controller core over a valid/ready handshake.
- Sits between the APB bus and the DRAM controller core.
- Inserts a parameterised number of wait states and flags bad accesses with pslverr.

Parameters:
NUM_WAIT, 1, wait cycles in ACCESS before pready (0..15)
TREFI_RST, 16'd780, reset value of TREFI register

Ports:
pclk  input  1  bus/core clock
preset  input  1  asynchronous active-low reset
psel  input  1  APB select
penable  input  1  APB access phase
pwrite  input  1  1=write, 0=read
paddr  input  16  byte address
pwdata  input  16  write data
prdata  output  16  read data, valid only with pready
pready  output  1  transfer complete
pslverr  output  1  error response, valid only with pready
cfg_enable  output  1  CTRL[0]
cfg_refresh_en  output  1  CTRL[1]
cfg_trefi  output  16  TREFI
cfg_trcd  output  4  TIMING[3:0]
cfg_trp  output  4  TIMING[7:4]
cfg_tcas  output  4  TIMING[11:8]
cmd_valid  output  1  command pending to core
cmd_op  output  2  command opcode
cmd_addr  output  16  command address (CMD_ADDR register)
cmd_ready  input  1  core accepts command
core_busy  input  1  core status
init_done  input  1  core status

Behaviour:
- Reset (preset=0, async): FSM=IDLE; prdata=0, pready=0, pslverr=0; CTRL=0, TREFI=TREFI_RST, TIMING=16'h0333, CMD_ADDR=0; cmd_valid=0, cmd_op=0.
- Register map:
  - 0x0000 CTRL: RW, bits[1:0]; upper bits read 0.
  - 0x0002 TREFI: RW.
  - 0x0004 TIMING: RW, [11:0]; [15:12] read 0, ignored on write.
  - 0x0006 CMD_ADDR: RW.
  - 0x0008 CMD: write-only; a write sets cmd_op=pwdata[1:0] and cmd_valid=1; a read gives pslverr.
  - 0x000A STATUS: RO = {13'b0, init_done, core_busy, cmd_valid}; a write gives pslverr.
- Error responses: unmapped address or paddr[0]=1 → pslverr=1, prdata=0, no state change.
- FSM states:
  - IDLE: on edge with psel=1 & penable=0 (SETUP) → ACCESS; wait counter loaded with NUM_WAIT.
  - ACCESS: counter decrements each edge while psel&penable, down to 0.
- pready is registered-state-derived: pready = (state==ACCESS) && (cnt==0) && psel && penable. No other combinational bus path.
- Transfer timing: SETUP at cycle T, pready high at cycle T+1+NUM_WAIT; total transfer 2+NUM_WAIT cycles. After the pready edge → IDLE.
- Back-to-back: a new SETUP the cycle after completion is accepted normally.
- Commit: register write and CMD launch happen on the rising edge where psel&penable&pready&pwrite and no error.
- Read data: prdata and pslverr are driven only while pready=1, else 0. Read data reflects the pre-edge register value.
- Abort: psel=0 while in ACCESS before pready → IDLE, no write, no response.
- Command handshake:
  - cmd_valid, cmd_op and cmd_addr stay stable until cmd_valid&cmd_ready at an edge; cmd_valid then clears next cycle.
  - CMD write while cmd_valid=1 (pre-edge value) → pslverr, command unchanged. This holds even if cmd_ready=1 on the same edge.
  - CMD_ADDR write while cmd_valid=1 → pslverr, so cmd_addr cannot change under a pending command.
- Reset mid-transfer: immediate return to IDLE, all outputs to reset values, pending command dropped.

Test Plan:
- Reset then read TREFI, TIMING, CTRL with NUM_WAIT=1 → prdata 16'd780, 16'h0333, 0; pready high at the 3rd cycle from SETUP; pslverr=0.
- Write TIMING=16'hF5A7, read back → 16'h05A7; cfg_trcd=7, cfg_trp=A, cfg_tcas=5 one cycle after the commit edge.
- Write CMD_ADDR=16'h1234, then CMD=2'b10 with cmd_ready=0 → cmd_valid=1, cmd_op=2, cmd_addr=16'h1234. Second CMD write → pslverr=1. Raise cmd_ready one cycle → cmd_valid=0; STATUS reads bit0=0.
- Access 0x0003 and 0x0020, write STATUS, read CMD → pslverr=1, prdata=0, registers unchanged.
- Drop psel during a write ACCESS wait cycle (NUM_WAIT=3) → no pready, register unchanged. Next transfer completes normally.
- Assert preset low mid-ACCESS with cmd_valid=1 → pready=0, cmd_valid=0, registers return to reset values asynchronously.
